dram_arbiter: RTL
=================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default `DRAM_ADDRESS_SIZE, which is the DRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default `DRAM_WORD_SIZE, which is the DRAM data width.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous reset, active-low (reset==0 resets).
REQ-005 SHALL have ports i_req, input, 1 bit, and i_address, input, ADDR_W bits: instruction-side read request.
REQ-006 SHALL have ports i_rdata, output, DATA_W bits, i_rvalid, output, 1 bit, and i_ack, output, 1 bit: instruction-side read data, data strobe, and completion.
REQ-007 SHALL have ports d_req, input, 1 bit, d_we, input, 1 bit, d_address, input, ADDR_W bits, and d_wdata, input, DATA_W bits: data-side request (d_we=1 selects write).
REQ-008 SHALL have ports d_rdata, output, DATA_W bits, d_rvalid, output, 1 bit, and d_ack, output, 1 bit: data-side read data, data strobe, and completion.
REQ-009 SHALL have ports dram_address, output, ADDR_W bits, and dram_data, inout, DATA_W bits: DRAM bus.
REQ-010 SHALL have ports dram_read_enable and dram_write_enable, outputs, 1 bit each: DRAM command enables.
REQ-011 SHALL have ports dram_read_data_enable, dram_write_data_enable, and dram_acknowledge, inputs, 1 bit each: DRAM strobes and completion.

Function
REQ-012 SHALL implement FSM states IDLE, READ, WRITE, RELEASE.
REQ-013 In IDLE with any request pending, SHALL grant one requester per REQ-029/030, register its address, op and write data, and go to READ (read) or WRITE (d_we=1) on the next edge.
REQ-014 The grant SHALL be one cycle: a request sampled in IDLE at edge N SHALL assert the dram enable from edge N+1.
REQ-015 In READ/WRITE, SHALL hold dram_read_enable/dram_write_enable=1 and dram_address=registered address until dram_acknowledge=1.
REQ-016 When dram_acknowledge=1 in READ/WRITE, SHALL assert the granted requester's ack combinationally that cycle, for exactly one cycle, and go to RELEASE.
REQ-017 In RELEASE, SHALL drive both enables 0 for exactly one cycle, which clears the DRAM delay lines, then go to IDLE.
REQ-018 Back-to-back transactions SHALL have a minimum spacing of 3 cycles from ack to the next enable (RELEASE, IDLE, enable).
REQ-019 In READ, SHALL forward dram_data to the granted x_rdata and set x_rvalid=dram_read_data_enable; the non-granted rvalid SHALL be 0.
REQ-020 SHALL drive dram_data with registered d_wdata only in WRITE while dram_write_data_enable=1; otherwise dram_data SHALL be high-Z.
REQ-021 Requesters SHALL hold req and address until ack; changes mid-transaction SHALL be ignored.
REQ-022 A dropped req SHALL NOT abort the transaction in flight.
REQ-023 dram_acknowledge in IDLE or RELEASE SHALL be ignored and SHALL produce no ack.
REQ-024 i_ack, d_ack, i_rvalid, and d_rvalid SHALL never be 1 in the same cycle.
REQ-025 A d_req with d_we=1 SHALL never assert dram_read_enable.
REQ-026 The icache side SHALL never issue writes.

Reset
REQ-027 On reset==0 at an edge, SHALL go to IDLE, drive dram_read_enable=dram_write_enable=0, dram_address=0, dram_data high-Z, all acks/rvalids 0, and set the last-grant pointer to instruction side. This SHALL apply mid-transaction.
REQ-028 After reset release, arbitration SHALL resume in the first IDLE cycle; no stale ack SHALL be produced.

Configuration
REQ-029 With macro DRAM_ARB_ROUND_ROBIN_EN defined: when both req=1 in IDLE, SHALL grant the side not granted last. The last-grant pointer SHALL update on every grant.
REQ-030 Without DRAM_ARB_ROUND_ROBIN_EN: fixed priority, data side always wins when both request. The pointer logic SHALL be absent.

Verification
REQ-031 reset=0 asserted during READ of address 0x10 -> next cycle enables=0, state IDLE, no i_ack; after release, fresh i_req 0x20 completes normally.
REQ-032 i_req only, address 0x10, DRAM preloaded 0xDEADBEEF -> dram_read_enable from N+1 to ack; i_rvalid with i_rdata=0xDEADBEEF; one i_ack pulse; enable 0 in RELEASE.
REQ-033 d_req, d_we=1, address 0x04, d_wdata=0x12345678 -> dram_data=0x12345678 only while dram_write_data_enable; d_ack one pulse; readback of 0x04 returns 0x12345678.
REQ-034 i_req and d_req asserted together, held continuously, DRAM_ARB_ROUND_ROBIN_EN defined -> grants alternate D,I,D,I over 4 transactions; without macro, D granted until d_req dropped.
REQ-035 Two consecutive d reads, 0x08 then 0x0C -> at least one RELEASE cycle with both enables 0 between them; second data correct.

Source files
------------

// File: rtl/dram_arbiter.sv
// ============================================================================
// dram_arbiter -- grants a single DRAM port to an instruction-side reader and a
//                 data-side reader/writer, one transaction at a time.
// Build option : DRAM_ARB_ROUND_ROBIN_EN (round-robin on contention; default is
//                fixed priority with the data side winning).
// Revision     : 1.0 -- initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 24
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif

module dram_arbiter #(
   parameter int ADDR_W = `DRAM_ADDRESS_SIZE,
   parameter int DATA_W = `DRAM_WORD_SIZE
) (
   input  logic              clock,
   input  logic              reset,

   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_address,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_rvalid,
   output logic              i_ack,

   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_rvalid,
   output logic              d_ack,

   output logic [ADDR_W-1:0] dram_address,
   inout  wire  [DATA_W-1:0] dram_data,
   output logic              dram_read_enable,
   output logic              dram_write_enable,
   input  logic              dram_read_data_enable,
   input  logic              dram_write_data_enable,
   input  logic              dram_acknowledge
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_READ    = 2'd1,
      S_WRITE   = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_gnt_d;
   logic              w_any_req;
   logic              w_pick_d;
   logic              w_busy;
   logic              w_grant;

   assign w_any_req = i_req | d_req;
   assign w_grant   = (r_state == S_IDLE) && w_any_req;
   assign w_busy    = (r_state == S_READ) || (r_state == S_WRITE);

`ifdef DRAM_ARB_ROUND_ROBIN_EN
   // Last-grant pointer: 1 = data side was granted last.
   logic r_last_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_last_d <= 1'b0;
      end else if (w_grant) begin
         r_last_d <= w_pick_d;
      end
   end

   assign w_pick_d = d_req && (!i_req || !r_last_d);
`else
   assign w_pick_d = d_req;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_gnt_d <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_addr  <= w_pick_d ? d_address : i_address;
            r_wdata <= d_wdata;
            r_gnt_d <= w_pick_d;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_state_nxt = (w_pick_d && d_we) ? S_WRITE : S_READ;
            end
         end
         S_READ, S_WRITE: begin
            if (dram_acknowledge) begin
               w_state_nxt = S_RELEASE;
            end
         end
         S_RELEASE: w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      dram_read_enable  = (r_state == S_READ);
      dram_write_enable = (r_state == S_WRITE);
      dram_address      = r_addr;

      i_ack    = w_busy && dram_acknowledge && !r_gnt_d;
      d_ack    = w_busy && dram_acknowledge &&  r_gnt_d;
      i_rvalid = (r_state == S_READ) && dram_read_data_enable && !r_gnt_d;
      d_rvalid = (r_state == S_READ) && dram_read_data_enable &&  r_gnt_d;

      i_rdata = '0;
      d_rdata = '0;
      if (r_state == S_READ) begin
         if (r_gnt_d) begin
            d_rdata = dram_data;
         end else begin
            i_rdata = dram_data;
         end
      end
   end

   // The bus is released except during the DRAM's write-data window.
   assign dram_data = ((r_state == S_WRITE) && dram_write_data_enable) ? r_wdata : 'z;

endmodule

`default_nettype wire
